// File: rtl/load_unit.sv
// load_unit
//   RV32I LOAD execution unit. On an accepted start it computes the
//   effective address (in1 + sext(imm)), issues a byte-lane read request to
//   data memory, waits for the response (with a timeout), and returns the
//   sign- or zero-extended result. Only one load is in flight at a time.
//
// Handshake contract:
//   d_req is high for the whole of REQ and drops on the cycle d_gnt is seen.
//   d_gnt is only honoured in REQ, d_rvalid only in WAIT, start only in IDLE.
//   A response beat is consumed the cycle d_rvalid is high in WAIT.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             issue request (sampled in IDLE)
//   opcode, funct3    instruction fields; only opcode 7'b0000011 is accepted
//   imm, in1          I-type immediate and base register
//   d_addr            registered effective address
//   d_req, rd_en      read request and byte-lane mask (valid in REQ)
//   d_gnt             memory accepted the request
//   d_rvalid, d_rdata read response
//   busy, done        not-IDLE flag and one-cycle completion pulse
//   rd_data, err      extended result and error flag, held after done
//   state_dbg         current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
module load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [11:0] imm,
  input  logic [31:0] in1,
  output logic [31:0] d_addr,
  output logic        d_req,
  output logic [3:0]  rd_en,
  input  logic        d_gnt,
  input  logic        d_rvalid,
  input  logic [31:0] d_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        err,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       f3_q;
  logic [3:0]       mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_load;
  logic             f3_ok;
  logic [31:0]      eff_addr;
  logic [31:0]      ext_data;
  logic [3:0]       new_mask;

  function automatic logic funct3_valid(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_valid = 1'b1;
      default:                                funct3_valid = 1'b0;
    endcase
  endfunction

  assign is_load  = start && (opcode == OP_LOAD);
  assign f3_ok    = funct3_valid(funct3);
  assign eff_addr = in1 + {{20{imm[11]}}, imm};
  assign cnt_inc  = cnt_q + 1'b1;

  // Lane mask: low two bits of funct3 select byte/half/word.
  always_comb begin
    new_mask = 4'b0000;
    case (funct3[1:0])
      2'b00:   new_mask = 4'b0001;
      2'b01:   new_mask = 4'b0011;
      2'b10:   new_mask = 4'b1111;
      default: new_mask = 4'b0000;
    endcase
  end

  // Extension uses the funct3 latched at accept, not the live input.
  always_comb begin
    ext_data = d_rdata;
    case (f3_q)
      3'b000:  ext_data = {{24{d_rdata[7]}}, d_rdata[7:0]};
      3'b001:  ext_data = {{16{d_rdata[15]}}, d_rdata[15:0]};
      3'b100:  ext_data = {24'b0, d_rdata[7:0]};
      3'b101:  ext_data = {16'b0, d_rdata[15:0]};
      default: ext_data = d_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    d_req     = 1'b0;
    rd_en     = 4'b0000;
    busy      = 1'b1;
    done      = 1'b0;
    state_dbg = state_q;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (is_load) state_d = f3_ok ? S_REQ : S_DONE;
      end
      S_REQ: begin
        d_req = 1'b1;
        rd_en = mask_q;
        if (d_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data on the expiry cycle still wins over the timeout.
        if (d_rvalid || (cnt_inc == TMO)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_addr  <= '0;
      mask_q  <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_load) begin
            rd_data <= '0;
            if (f3_ok) begin
              d_addr <= eff_addr;
              mask_q <= new_mask;
              f3_q   <= funct3;
              err    <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (d_gnt) cnt_q <= '0;
        end
        S_WAIT: begin
          if (d_rvalid) begin
            rd_data <= ext_data;
            err     <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == TMO) begin
              rd_data <= '0;
              err     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] in1;
  logic [31:0] d_addr;
  logic        d_req;
  logic [3:0]  rd_en;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        busy;
  logic        done;
  logic [31:0] rd_data;
  logic        err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  load_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .funct3(funct3), .imm(imm), .in1(in1), .d_addr(d_addr),
    .d_req(d_req), .rd_en(rd_en), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .busy(busy), .done(done), .rd_data(rd_data),
    .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: one full load with chosen grant / response delays
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] base, input logic [11:0] immv,
                         input int gnt_delay, input int rv_delay,
                         input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_wait);
    int req_cycles;
    int k;
    logic [31:0] want;
    exp_q.push_back(exp_data);
    start = 1'b1; opcode = OP_LOAD; funct3 = f3; imm = immv; in1 = base;
    tick;
    start = 1'b0; in1 = $urandom; imm = 12'($urandom_range(0, 4095));
    check({tag, ".addr"}, d_addr, exp_addr);
    check({tag, ".mask"}, {28'b0, rd_en}, {28'b0, exp_mask});
    req_cycles = 0;
    for (int i = 0; i < gnt_delay; i++) begin
      if (d_req) req_cycles++;
      tick;
    end
    d_gnt = 1'b1;
    if (d_req) req_cycles++;
    tick;
    d_gnt = 1'b0;
    check({tag, ".req_cycles"}, req_cycles, gnt_delay + 1);
    check({tag, ".req_low"}, {31'b0, d_req}, 32'd0);
    check({tag, ".mask_low"}, {28'b0, rd_en}, 32'd0);
    k = 0;
    d_rdata = rdata;
    while (!done && k < 40) begin
      d_rvalid = (k == rv_delay);
      tick;
      d_rvalid = 1'b0;
      k++;
    end
    check({tag, ".wait_cycles"}, k, exp_wait);
    check({tag, ".done"}, {31'b0, done}, 32'd1);
    want = exp_q.pop_front();
    check({tag, ".rd_data"}, rd_data, want);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    tick;
    check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, ".idle"}, {31'b0, busy}, 32'd0);
    check({tag, ".held"}, rd_data, want);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; imm = '0; in1 = '0;
    d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = '0;
    repeat (3) tick;
    check("rst.state", {30'b0, state_dbg}, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.d_addr", d_addr, 32'd0);
    check("rst.rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    tick;

    // LW, grant on first REQ cycle, response on second WAIT cycle
    do_load("lw", 3'b010, 32'h1000, 12'h004, 0, 1, 32'hDEADBEEF,
            32'h1004, 4'b1111, 32'hDEADBEEF, 1'b0, 2);
    // LB / LBU with negative immediate
    do_load("lb", 3'b000, 32'h100, 12'hFFF, 0, 0, 32'h12345680,
            32'h000000FF, 4'b0001, 32'hFFFFFF80, 1'b0, 1);
    do_load("lbu", 3'b100, 32'h100, 12'hFFF, 1, 2, 32'h12345680,
            32'h000000FF, 4'b0001, 32'h00000080, 1'b0, 3);
    // LH / LHU with grant held off, d_req up for 3 cycles
    do_load("lh", 3'b001, 32'h2000, 12'h002, 2, 0, 32'hAAAA8001,
            32'h00002002, 4'b0011, 32'hFFFF8001, 1'b0, 1);
    do_load("lhu", 3'b101, 32'h2000, 12'h002, 2, 0, 32'hAAAA8001,
            32'h00002002, 4'b0011, 32'h00008001, 1'b0, 1);
    // address wrap-around
    do_load("wrap", 3'b010, 32'hFFFFFFFF, 12'h002, 0, 0, 32'h0BADF00D,
            32'h00000001, 4'b1111, 32'h0BADF00D, 1'b0, 1);
    // timeout, then data arriving exactly on the expiry cycle
    do_load("tmo", 3'b010, 32'h40, 12'h000, 0, 99, 32'h55555555,
            32'h00000040, 4'b1111, 32'h00000000, 1'b1, 16);
    do_load("tmo_edge", 3'b010, 32'h40, 12'h000, 0, 15, 32'hCAFEF00D,
            32'h00000040, 4'b1111, 32'hCAFEF00D, 1'b0, 16);

    // bad funct3: straight to DONE with err, no request; start in DONE ignored
    start = 1'b1; opcode = OP_LOAD; funct3 = 3'b011; in1 = 32'h8000; imm = 12'h0;
    tick;
    funct3 = 3'b010;
    check("bad.done", {31'b0, done}, 32'd1);
    check("bad.err", {31'b0, err}, 32'd1);
    check("bad.req", {31'b0, d_req}, 32'd0);
    check("bad.rd_data", rd_data, 32'd0);
    check("bad.addr_kept", d_addr, 32'hCAFEF00D & 32'h0 | 32'h00000040);
    tick;
    start = 1'b0;
    check("bad.ignored_start", {31'b0, busy}, 32'd0);
    check("bad.done_pulse", {31'b0, done}, 32'd0);

    // non-load opcode: nothing happens
    start = 1'b1; opcode = OP_STORE; funct3 = 3'b010;
    tick;
    start = 1'b0;
    check("store.busy", {31'b0, busy}, 32'd0);
    check("store.req", {31'b0, d_req}, 32'd0);
    tick;
    check("store.done", {31'b0, done}, 32'd0);

    // reset during WAIT, late response afterwards is ignored
    start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; in1 = 32'h3000; imm = 12'h010;
    tick;
    start = 1'b0; d_gnt = 1'b1;
    tick;
    d_gnt = 1'b0;
    tick;
    check("abort.in_wait", {30'b0, state_dbg}, 32'd2);
    check("abort.addr_before", d_addr, 32'h3010);
    rst_n = 1'b0;
    #1;
    check("abort.state", {30'b0, state_dbg}, 32'd0);
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.d_addr", d_addr, 32'd0);
    check("abort.done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d_rvalid = 1'b1; d_rdata = 32'h77777777;
    tick;
    d_rvalid = 1'b0;
    check("late.done", {31'b0, done}, 32'd0);
    check("late.rd_data", rd_data, 32'd0);
    check("late.busy", {31'b0, busy}, 32'd0);
    do_load("post_rst", 3'b010, 32'h1000, 12'h004, 0, 1, 32'h01234567,
            32'h1004, 4'b1111, 32'h01234567, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
